// File: rtl/sd_buf_dma.sv
// sd_buf_dma: register-programmed DMA engine that copies 32-bit words between the
// SD DMA buffer's CPU-side port and system memory, with a completion interrupt.
module sd_buf_dma #(
    parameter int BUF_AW = 10,
    parameter int CNT_W  = 11
) (
    input  logic              clkCPU,
    input  logic              globlRst,
    input  logic [31:0]       addrBus,
    input  logic [31:0]       dataInBus,
    input  logic [3:0]        weBus,
    input  logic              en_reg,
    output logic [31:0]       dataOut_reg,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [31:0]       buf_dout,
    input  logic [31:0]       buf_din,
    output logic [3:0]        buf_we,
    output logic              buf_en,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_dout,
    input  logic [31:0]       mem_din,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              dmaInt
);

    typedef enum logic [2:0] {
        IDLE,
        B_RD,
        B_LAT,
        M_WR,
        M_RD,
        B_WR,
        DONE_ST
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 ** BUF_AW);

    // Programming registers
    logic              dir_q, dir_d;
    logic              irqen_q, irqen_d;
    logic [BUF_AW-1:0] bufbase_q, bufbase_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [31:2]       memaddr_q, memaddr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Transfer engine
    state_t            state_q, state_d;
    logic [BUF_AW-1:0] bptr_q, bptr_d;
    logic [31:2]       mptr_q, mptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              abort_pend_q, abort_pend_d;

    // Registered outputs
    logic [31:0]       rdata_q, rdata_d;
    logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
    logic [31:0]       buf_dout_q, buf_dout_d;
    logic [3:0]        buf_we_q, buf_we_d;
    logic              buf_en_q, buf_en_d;
    logic [31:2]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_dout_q, mem_dout_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              irq_q, irq_d;

    // Bus decode
    logic busy;
    logic wr;
    logic wr_ctrl, wr_stat, wr_maddr, wr_count;
    logic start, abort_req, abort_now;
    logic set_done, set_aborted, advance;

    assign busy      = (state_q != IDLE);
    assign wr        = en_reg && (weBus != 4'h0);
    assign wr_ctrl   = wr && (addrBus[3:2] == 2'd0);
    assign wr_stat   = wr && (addrBus[3:2] == 2'd1);
    assign wr_maddr  = wr && (addrBus[3:2] == 2'd2);
    assign wr_count  = wr && (addrBus[3:2] == 2'd3);
    assign start     = wr_ctrl && dataInBus[0] && !busy;
    assign abort_req = wr_ctrl && dataInBus[3] && busy;
    assign abort_now = abort_pend_q || abort_req;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addrBus[31:4], addrBus[1:0]};

    // NOTE: every _d gets its hold value first so no path through this block
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        dir_d        = dir_q;
        irqen_d      = irqen_q;
        bufbase_d    = bufbase_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        memaddr_d    = memaddr_q;
        count_d      = count_q;
        state_d      = state_q;
        bptr_d       = bptr_q;
        mptr_d       = mptr_q;
        rem_d        = rem_q;
        abort_pend_d = abort_pend_q;
        rdata_d      = rdata_q;
        buf_addr_d   = buf_addr_q;
        buf_dout_d   = buf_dout_q;
        mem_addr_d   = mem_addr_q;
        mem_dout_d   = mem_dout_q;
        set_done     = 1'b0;
        set_aborted  = 1'b0;
        advance      = 1'b0;

        // IRQEN stays writable during a transfer; the transfer shape does not.
        if (wr_ctrl) begin
            irqen_d = dataInBus[2];
            if (!busy) begin
                dir_d     = dataInBus[1];
                bufbase_d = dataInBus[16 +: BUF_AW];
            end
        end
        if (wr_maddr && !busy) begin
            memaddr_d = dataInBus[31:2];
        end
        if (wr_count && !busy) begin
            count_d = dataInBus[CNT_W-1:0];
        end
        if (wr_stat) begin
            if (dataInBus[1]) done_d    = 1'b0;
            if (dataInBus[2]) aborted_d = 1'b0;
        end
        if (abort_req) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (start) begin
                    bptr_d    = dataInBus[16 +: BUF_AW];
                    mptr_d    = memaddr_q;
                    rem_d     = (count_q > MAX_CNT) ? MAX_CNT : count_q;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    if (count_q == '0) begin
                        state_d = DONE_ST;
                    end else if (dataInBus[1]) begin
                        state_d = M_RD;
                    end else begin
                        state_d = B_RD;
                    end
                end
            end
            B_RD: begin
                if (abort_now) begin
                    state_d     = IDLE;
                    set_aborted = 1'b1;
                end else begin
                    state_d = B_LAT;
                end
            end
            B_LAT: begin
                if (abort_now) begin
                    state_d     = IDLE;
                    set_aborted = 1'b1;
                end else begin
                    mem_dout_d = buf_din;
                    state_d    = M_WR;
                end
            end
            M_WR: begin
                // An abort never cuts a memory handshake short.
                if (mem_ack) begin
                    advance = 1'b1;
                    if (abort_now) begin
                        state_d     = IDLE;
                        set_aborted = 1'b1;
                    end else if (rem_q == CNT_W'(1)) begin
                        state_d = DONE_ST;
                    end else begin
                        state_d = B_RD;
                    end
                end
            end
            M_RD: begin
                if (mem_ack) begin
                    buf_dout_d = mem_din;
                    if (abort_now) begin
                        state_d     = IDLE;
                        set_aborted = 1'b1;
                    end else begin
                        state_d = B_WR;
                    end
                end
            end
            B_WR: begin
                advance = 1'b1;
                if (abort_now) begin
                    state_d     = IDLE;
                    set_aborted = 1'b1;
                end else if (rem_q == CNT_W'(1)) begin
                    state_d = DONE_ST;
                end else begin
                    state_d = M_RD;
                end
            end
            DONE_ST: begin
                set_done     = 1'b1;
                abort_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            bptr_d = bptr_q + BUF_AW'(1);
            mptr_d = mptr_q + 30'd1;
            rem_d  = rem_q - CNT_W'(1);
        end

        // Hardware sets are applied after software clears so a set wins.
        if (set_done)    done_d    = 1'b1;
        if (set_aborted) aborted_d = 1'b1;

        // Outputs are decoded from the next state so they line up with state_q.
        buf_en_d  = (state_d == B_RD) || (state_d == B_WR);
        buf_we_d  = (state_d == B_WR) ? 4'hF : 4'h0;
        mem_req_d = (state_d == M_WR) || (state_d == M_RD);
        mem_we_d  = (state_d == M_WR);
        if (buf_en_d) begin
            buf_addr_d = bptr_d;
        end
        if (mem_req_d) begin
            mem_addr_d = mptr_d;
        end
        irq_d = irqen_q && (done_q || aborted_q);

        if (en_reg) begin
            rdata_d = '0;
            case (addrBus[3:2])
                2'd0: begin
                    rdata_d[16 +: BUF_AW] = bufbase_q;
                    rdata_d[2]            = irqen_q;
                    rdata_d[1]            = dir_q;
                end
                2'd1:    rdata_d[2:0] = {aborted_q, done_q, busy};
                2'd2:    rdata_d      = {memaddr_q, 2'b00};
                default: rdata_d[CNT_W-1:0] = count_q;
            endcase
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the values of the previous cycle regardless of statement order.
    always_ff @(posedge clkCPU) begin
        if (globlRst) begin
            dir_q        <= 1'b0;
            irqen_q      <= 1'b0;
            bufbase_q    <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            memaddr_q    <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            bptr_q       <= '0;
            mptr_q       <= '0;
            rem_q        <= '0;
            abort_pend_q <= 1'b0;
            rdata_q      <= '0;
            buf_addr_q   <= '0;
            buf_dout_q   <= '0;
            buf_we_q     <= 4'h0;
            buf_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_dout_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            dir_q        <= dir_d;
            irqen_q      <= irqen_d;
            bufbase_q    <= bufbase_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            memaddr_q    <= memaddr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            bptr_q       <= bptr_d;
            mptr_q       <= mptr_d;
            rem_q        <= rem_d;
            abort_pend_q <= abort_pend_d;
            rdata_q      <= rdata_d;
            buf_addr_q   <= buf_addr_d;
            buf_dout_q   <= buf_dout_d;
            buf_we_q     <= buf_we_d;
            buf_en_q     <= buf_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_dout_q   <= mem_dout_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            irq_q        <= irq_d;
        end
    end

    assign dataOut_reg = rdata_q;
    assign buf_addr    = buf_addr_q;
    assign buf_dout    = buf_dout_q;
    assign buf_we      = buf_we_q;
    assign buf_en      = buf_en_q;
    assign mem_addr    = {mem_addr_q, 2'b00};
    assign mem_dout    = mem_dout_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign dmaInt      = irq_q;

endmodule

// File: doc/sd_buf_dma.md
Name: sd_buf_dma

Overview:
- Single-clock DMA engine that sits directly in front of the SD DMA buffer's CPU-side data port (addra/dina/wea/ena/douta).
- Copies N 32-bit words between the buffer and system memory, so the CPU no longer moves each SD sector word by word.
- Programmed through four control registers on the SoC bus.
- Raises a level interrupt when a transfer completes.

Parameters:
- BUF_AW, 10, buffer word-address width; buffer holds 2^BUF_AW words.
- CNT_W, 11, COUNT register width; maximum count is 2^BUF_AW.

Ports:
- clkCPU  in  1  system clock; all logic on its rising edge.
- globlRst  in  1  synchronous, active-high reset.
- addrBus  in  32  CPU bus address; bits [3:2] select the register.
- dataInBus  in  32  CPU write data.
- weBus  in  4  CPU byte write enables; any bit set means a write.
- en_reg  in  1  register-file select.
- dataOut_reg  out  32  registered read data; 1-cycle latency.
- buf_addr  out  BUF_AW  buffer word address.
- buf_dout  out  32  write data to the buffer.
- buf_din  in  32  buffer read data; valid 1 cycle after buf_en.
- buf_we  out  4  buffer byte write enables.
- buf_en  out  1  buffer port enable.
- mem_addr  out  32  memory byte address; bits [1:0] are always 0.
- mem_dout  out  32  write data to memory.
- mem_din  in  32  memory read data; valid in the cycle mem_ack is high.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write strobe (1 = write).
- mem_ack  in  1  memory acknowledge.
- dmaInt  out  1  level interrupt.

Behaviour:

Register map (addrBus[3:2]):
- 0 CTRL
  - bit0 START: write-1 pulse.
  - bit1 DIR: 0 = buffer to memory, 1 = memory to buffer.
  - bit2 IRQEN.
  - bit3 ABORT: write-1 pulse.
  - bits[16+BUF_AW-1:16] BUFBASE.
- 1 STATUS
  - bit0 BUSY: read-only.
  - bit1 DONE: sticky; write 1 clears.
  - bit2 ABORTED: sticky; write 1 clears.
- 2 MEMADDR: bits[1:0] read as 0.
- 3 COUNT: CNT_W bits.

Register access rules:
- Reads return the register value 1 cycle after en_reg.
- Register writes apply only when weBus != 0. Individual byte lanes are ignored; the full word is written.
- While BUSY, writes to MEMADDR, COUNT, DIR, BUFBASE and START are ignored. ABORT and STATUS clears are still honoured.

Reset (globlRst = 1 at a clock edge):
- All registers are 0, FSM is IDLE.
- dataOut_reg = 0, buf_en = 0, buf_we = 0, mem_req = 0, mem_we = 0, dmaInt = 0.
- buf_addr, mem_addr, buf_dout and mem_dout are 0.
- Reset mid-transfer drops mem_req immediately. The memory side must tolerate this.

Start:
- START=1 while IDLE latches the working pointers: bptr = BUFBASE, mptr = MEMADDR, remaining = COUNT.
- It also clears DONE and ABORTED.
- COUNT = 0: go straight to DONE_ST; no bus activity.
- COUNT > 2^BUF_AW: clamp to 2^BUF_AW.

FSM states: IDLE, B_RD, B_LAT, M_WR, M_RD, B_WR, DONE_ST.
- DIR = 0, per word:
  - B_RD: buf_en = 1, buf_we = 0, buf_addr = bptr.
  - B_LAT: capture buf_din into a data register.
  - M_WR: mem_req = 1, mem_we = 1, mem_addr = mptr, mem_dout = data. Hold until mem_ack.
  - On ack: advance, then go to B_RD, or DONE_ST if remaining becomes 0.
- DIR = 1, per word:
  - M_RD: mem_req = 1, mem_we = 0. Hold until mem_ack; capture mem_din on ack.
  - B_WR: buf_en = 1, buf_we = 4'hF, buf_dout = data, for exactly one cycle.
  - Then advance, and go to M_RD or DONE_ST.
- Advance means:
  - bptr <= bptr + 1, wrapping modulo 2^BUF_AW (address 2^BUF_AW - 1 wraps to 0).
  - mptr <= mptr + 4, wrapping modulo 2^32.
  - remaining <= remaining - 1.
- Throughput with zero-wait ack (ack in the same cycle as req): DIR = 0 is 3 cycles/word; DIR = 1 is 2 cycles/word.
- DONE_ST (1 cycle): set DONE, go to IDLE. BUSY = (state != IDLE).

Abort:
- ABORT while BUSY: if in M_WR or M_RD, finish the current memory handshake first (never deassert mem_req before ack).
- Then go to IDLE and set ABORTED. DONE is not set.
- ABORT while IDLE is ignored.

Interrupt:
- dmaInt = IRQEN & (DONE | ABORTED). It is registered, so it asserts 1 cycle after the flag sets.

Simultaneous events:
- A DONE/ABORTED set and a software clear in the same cycle: the set wins.
- START and ABORT in the same write while IDLE: START wins; ABORT is ignored.

Handshake invariants:
- mem_addr, mem_dout and mem_we are stable while mem_req = 1 and mem_ack = 0.
- mem_ack while mem_req = 0 is ignored.

Test Plan:
1. Preload buffer[0..3] = 0x11111111..0x44444444; MEMADDR = 0x1000, COUNT = 4, CTRL = 0x5 (DIR 0, IRQEN); zero-wait ack → memory writes at 0x1000, 0x1004, 0x1008, 0x100C with those words; BUSY for 12 cycles + DONE_ST; DONE = 1; dmaInt = 1 one cycle later.
2. DIR 1, BUFBASE = 0x3FE, COUNT = 3, MEMADDR = 0x2000, memory returns 0xA0, 0xA1, 0xA2 → buffer[0x3FE] = 0xA0, buffer[0x3FF] = 0xA1, buffer[0x000] = 0xA2 (wrap verified).
3. DIR 0, COUNT = 2, mem_ack delayed 5 cycles per request → mem_req held high with stable address and data; exactly 2 writes; no extra buffer reads.
4. COUNT = 0, START → DONE = 1 within 2 cycles; buf_en and mem_req never asserted.
5. ABORT asserted in M_WR while ack is stalled → mem_req stays high until ack; then IDLE, ABORTED = 1, DONE = 0; a write of 0x4 to STATUS clears ABORTED and dmaInt.
6. globlRst = 1 mid-transfer (word 2 of 8) → next cycle all outputs 0 and BUSY = 0; a following START with COUNT = 1 completes normally.
